// File: rtl/cache_wb_pkg.sv
// Shared widths, entry layout and helpers for the write-back eviction buffer.
package cache_wb_pkg;

   localparam int LINE_SIZE       = 16;
   localparam int LINE_ADDR_WIDTH = 26;
   localparam int NUM_ENTRIES     = 4;
   localparam int LINE_BITS       = LINE_SIZE * 8;
   localparam int WB_PTR_W        = $clog2(NUM_ENTRIES);
   localparam int WB_CNT_W        = $clog2(NUM_ENTRIES + 1);

   typedef struct packed {
      logic [LINE_ADDR_WIDTH-1:0] addr;
      logic [LINE_BITS-1:0]       data;
      logic [LINE_SIZE-1:0]       byteen;
   } wb_entry_t;

   function automatic logic is_clean(input logic [LINE_SIZE-1:0] byteen);
      return (byteen == '0);
   endfunction

endpackage

// File: rtl/cache_wb_ctrl.sv
// Pointer, occupancy and handshake control for the write-back buffer FIFO.
import cache_wb_pkg::*;

module cache_wb_ctrl (
   input  logic                clk,
   input  logic                reset,
   input  logic                evict_valid,
   input  logic                evict_clean,
   input  logic                mem_req_ready,
   output logic                evict_ready,
   output logic                mem_req_valid,
   output logic                enq,
   output logic                deq,
   output logic [WB_PTR_W-1:0] head,
   output logic [WB_PTR_W-1:0] tail,
   output logic [WB_CNT_W-1:0] count,
   output logic                empty
);

   logic                full;
   logic [WB_CNT_W-1:0] count_next;

   assign full          = (count == WB_CNT_W'(NUM_ENTRIES));
   // Clean lines are always taken: they are dropped and need no slot.
   assign evict_ready   = !full || evict_clean;
   assign enq           = evict_valid && !evict_clean && !full;
   assign mem_req_valid = !empty;
   assign deq           = mem_req_valid && mem_req_ready;

   always_comb begin
      count_next = count;
      case ({enq, deq})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         empty <= 1'b1;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         count <= count_next;
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/cache_wb_buffer.sv
// Write-back eviction buffer: entry storage, valid bits and snoop compare.
// Optional snoop comparators are enabled by defining CS_WB_SNOOP_EN.
import cache_wb_pkg::*;

module cache_wb_buffer (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       evict_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] evict_addr,
   input  logic [LINE_BITS-1:0]       evict_data,
   input  logic [LINE_SIZE-1:0]       evict_byteen,
   output logic                       evict_ready,
   output logic                       mem_req_valid,
   output logic [LINE_ADDR_WIDTH-1:0] mem_req_addr,
   output logic [LINE_BITS-1:0]       mem_req_data,
   output logic [LINE_SIZE-1:0]       mem_req_byteen,
   input  logic                       mem_req_ready,
   input  logic [LINE_ADDR_WIDTH-1:0] snoop_addr,
   output logic                       snoop_hit,
   output logic                       empty,
   output logic [WB_CNT_W-1:0]        count
);

   logic                   enq;
   logic                   deq;
   logic [WB_PTR_W-1:0]    head;
   logic [WB_PTR_W-1:0]    tail;
   logic [NUM_ENTRIES-1:0] valid;
   wb_entry_t              entries [NUM_ENTRIES];

   cache_wb_ctrl u_ctrl (
      .clk           (clk),
      .reset         (reset),
      .evict_valid   (evict_valid),
      .evict_clean   (is_clean(evict_byteen)),
      .mem_req_ready (mem_req_ready),
      .evict_ready   (evict_ready),
      .mem_req_valid (mem_req_valid),
      .enq           (enq),
      .deq           (deq),
      .head          (head),
      .tail          (tail),
      .count         (count),
      .empty         (empty)
   );

   // Payload is never reset; valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (enq) entries[tail] <= '{addr: evict_addr, data: evict_data, byteen: evict_byteen};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
      end else begin
         if (enq) valid[tail] <= 1'b1;
         if (deq) valid[head] <= 1'b0;
      end
   end

   assign mem_req_addr   = entries[head].addr;
   assign mem_req_data   = entries[head].data;
   assign mem_req_byteen = entries[head].byteen;

`ifdef CS_WB_SNOOP_EN
   always_comb begin
      snoop_hit = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid[i] && (entries[i].addr == snoop_addr)) snoop_hit = 1'b1;
      end
   end
`else
   logic unused_snoop;
   assign unused_snoop = ^{snoop_addr, valid};
   assign snoop_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed self-checking bench for cache_wb_buffer.
module tb_cache_wb_buffer;
   import cache_wb_pkg::*;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       evict_valid;
   logic [LINE_ADDR_WIDTH-1:0] evict_addr;
   logic [LINE_BITS-1:0]       evict_data;
   logic [LINE_SIZE-1:0]       evict_byteen;
   logic                       evict_ready;
   logic                       mem_req_valid;
   logic [LINE_ADDR_WIDTH-1:0] mem_req_addr;
   logic [LINE_BITS-1:0]       mem_req_data;
   logic [LINE_SIZE-1:0]       mem_req_byteen;
   logic                       mem_req_ready;
   logic [LINE_ADDR_WIDTH-1:0] snoop_addr;
   logic                       snoop_hit;
   logic                       empty;
   logic [WB_CNT_W-1:0]        count;

   int tests  = 0;
   int failed = 0;
   logic hit_exp;

   always #5 clk = ~clk;

   cache_wb_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .evict_valid    (evict_valid),
      .evict_addr     (evict_addr),
      .evict_data     (evict_data),
      .evict_byteen   (evict_byteen),
      .evict_ready    (evict_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_byteen (mem_req_byteen),
      .mem_req_ready  (mem_req_ready),
      .snoop_addr     (snoop_addr),
      .snoop_hit      (snoop_hit),
      .empty          (empty),
      .count          (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [25:0] a, input logic [15:0] be, input logic [127:0] d);
      evict_valid  = 1'b1;
      evict_addr   = a;
      evict_byteen = be;
      evict_data   = d;
      #1;
   endtask

   task automatic idle_evict();
      evict_valid  = 1'b0;
      evict_byteen = '0;
      #1;
   endtask

   function automatic logic [127:0] pat(input logic [25:0] a);
      return {4{32'hC0DE_0000 | {6'd0, a}}};
   endfunction

   initial begin
`ifdef CS_WB_SNOOP_EN
      hit_exp = 1'b1;
`else
      hit_exp = 1'b0;
`endif
      reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
      evict_byteen = '0; mem_req_ready = 1'b0; snoop_addr = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: reset / idle state
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_valid", mem_req_valid, 0);
      chk("rst_ready", evict_ready, 1);
      chk("rst_hit",   snoop_hit, 0);

      // 2: single dirty eviction with memory ready
      mem_req_ready = 1'b1;
      offer(26'h10, 16'h000F, pat(26'h10));
      chk("t2_ready", evict_ready, 1);
      chk("t2_no_bypass", mem_req_valid, 0);
      tick();
      idle_evict();
      chk("t2_valid", mem_req_valid, 1);
      chk("t2_addr",  mem_req_addr, 26'h10);
      chk("t2_mask",  mem_req_byteen, 16'h000F);
      chk("t2_data",  mem_req_data, pat(26'h10));
      chk("t2_count", count, 1);
      tick();
      chk("t2_empty", empty, 1);
      chk("t2_valid_lo", mem_req_valid, 0);

      // 3: fill with memory stalled
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         offer(26'h30 + 26'(i), 16'hFFFF, pat(26'h30 + 26'(i)));
         tick();
      end
      idle_evict();
      chk("t3_count", count, 4);
      offer(26'h40, 16'h00F0, pat(26'h40));
      chk("t3_full_dirty_ready", evict_ready, 0);
      offer(26'h50, 16'h0000, pat(26'h50));
      chk("t3_full_clean_ready", evict_ready, 1);
      tick();
      idle_evict();
      chk("t3_clean_dropped", count, 4);
      chk("t3_head", mem_req_addr, 26'h30);

      // 4: full with simultaneous dequeue: no enqueue this cycle
      offer(26'h40, 16'h00F0, pat(26'h40));
      mem_req_ready = 1'b1;
      #1;
      chk("t4_ready_lo", evict_ready, 0);
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("t4_count3", count, 3);
      chk("t4_head31", mem_req_addr, 26'h31);
      chk("t4_ready_hi", evict_ready, 1);
      tick();
      idle_evict();
      chk("t4_count4", count, 4);

      mem_req_ready = 1'b1;
      #1;
      chk("t4_d31", mem_req_addr, 26'h31);
      tick();
      chk("t4_d32", mem_req_addr, 26'h32);
      tick();
      chk("t4_d33", mem_req_addr, 26'h33);
      tick();
      chk("t4_d40", mem_req_addr, 26'h40);
      chk("t4_d40_data", mem_req_data, pat(26'h40));
      chk("t4_d40_mask", mem_req_byteen, 16'h00F0);
      tick();
      chk("t4_drained", empty, 1);
      chk("t4_drained_cnt", count, 0);

      // 5/6: duplicates across pointer wrap, ordered release, snoop
      mem_req_ready = 1'b0;
      snoop_addr = 26'h21;
      offer(26'h20, 16'h0003, 128'h1111);
      tick();
      offer(26'h21, 16'h0300, 128'h2222);
      chk("t6_enq_no_hit", snoop_hit, 0);
      tick();
      offer(26'h20, 16'hC000, 128'h3333);
      tick();
      idle_evict();
      chk("t5_count", count, 3);
      chk("t6_hit_pending", snoop_hit, hit_exp);
      chk("t5_h0_addr", mem_req_addr, 26'h20);
      chk("t5_h0_data", mem_req_data, 128'h1111);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      tick();
      chk("t5_h1_addr", mem_req_addr, 26'h21);
      chk("t5_h1_data", mem_req_data, 128'h2222);
      chk("t5_h1_stable_cnt", count, 2);
      mem_req_ready = 1'b1;
      #1;
      chk("t6_hit_deq_cycle", snoop_hit, hit_exp);
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("t6_hit_after", snoop_hit, 0);
      chk("t5_h2_addr", mem_req_addr, 26'h20);
      chk("t5_h2_data", mem_req_data, 128'h3333);
      chk("t5_h2_mask", mem_req_byteen, 16'hC000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("t5_empty", empty, 1);

      // mid-operation reset discards pending entries
      offer(26'h60, 16'h0001, pat(26'h60));
      tick();
      offer(26'h61, 16'h0001, pat(26'h61));
      tick();
      idle_evict();
      chk("rst2_pre_cnt", count, 2);
      snoop_addr = 26'h60;
      #1;
      chk("rst2_pre_hit", snoop_hit, hit_exp);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst2_empty", empty, 1);
      chk("rst2_count", count, 0);
      chk("rst2_valid", mem_req_valid, 0);
      chk("rst2_hit", snoop_hit, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
